// File: rtl/prog_clk_gen.sv
// Multi-channel programmable clock generator.
// Each channel runs free or emits a counted burst of toggles.
module prog_clk_gen #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 8,
   parameter int BURST_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          ch_en,
   input  logic [NUM_CH-1:0]          mode,
   input  logic [NUM_CH*CNT_W-1:0]    half_period,
   input  logic [NUM_CH*BURST_W-1:0]  burst_len,
   input  logic [NUM_CH-1:0]          start,
   output logic [NUM_CH-1:0]          clk_out,
   output logic [NUM_CH-1:0]          busy,
   output logic [NUM_CH-1:0]          done
);

   typedef enum logic {IDLE, RUN} state_t;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_t             st_q, st_d;
      logic [CNT_W-1:0]   cnt_q, cnt_d;
      logic [CNT_W-1:0]   hp_q, hp_d, hp_raw, hp_in;
      logic [BURST_W-1:0] tc_q, tc_d, bl_in;
      logic               mode_q, mode_d;
      logic               co_q, co_d;
      logic               busy_q;
      logic               done_q, done_d;
      logic               hit;

      assign hp_raw = half_period[c*CNT_W +: CNT_W];
      assign hp_in  = (hp_raw == '0) ? CNT_W'(1) : hp_raw;
      assign bl_in  = burst_len[c*BURST_W +: BURST_W];
      assign hit    = (cnt_q == hp_q - CNT_W'(1));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            hp_q   <= '0;
            tc_q   <= '0;
            mode_q <= 1'b0;
            co_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
         end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            hp_q   <= hp_d;
            tc_q   <= tc_d;
            mode_q <= mode_d;
            co_q   <= co_d;
            busy_q <= (st_d == RUN);
            done_q <= done_d;
         end
      end

      always_comb begin
         st_d   = st_q;
         cnt_d  = cnt_q;
         hp_d   = hp_q;
         tc_d   = tc_q;
         mode_d = mode_q;
         co_d   = co_q;
         done_d = 1'b0;
         if (!ch_en[c]) begin
            st_d  = IDLE;
            cnt_d = '0;
            tc_d  = '0;
            co_d  = 1'b0;
         end else begin
            unique case (st_q)
               IDLE: begin
                  if (!mode[c]) begin
                     st_d   = RUN;
                     mode_d = 1'b0;
                     cnt_d  = '0;
                     hp_d   = hp_in;
                  end else if (start[c]) begin
                     mode_d = 1'b1;
                     cnt_d  = '0;
                     hp_d   = hp_in;
                     co_d   = 1'b0;
                     // An empty burst completes without ever running
                     if (bl_in == '0) begin
                        done_d = 1'b1;
                     end else begin
                        st_d = RUN;
                        tc_d = bl_in;
                     end
                  end
               end
               RUN: begin
                  if (hit) begin
                     co_d  = ~co_q;
                     cnt_d = '0;
                     hp_d  = hp_in;
                     if (mode_q) begin
                        tc_d = tc_q - BURST_W'(1);
                        if (tc_q == BURST_W'(1)) begin
                           st_d   = IDLE;
                           done_d = 1'b1;
                        end
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               default: st_d = IDLE;
            endcase
         end
      end

      assign clk_out[c] = co_q;
      assign busy[c]    = busy_q;
      assign done[c]    = done_q;
   end

endmodule

// File: tb/tb_prog_clk_gen.sv
// Scoreboard bench for prog_clk_gen.
// Expected per-cycle channel states are queued by stimulus, checked by a monitor.
module tb_prog_clk_gen;
   localparam int NC = 4;
   localparam int CW = 8;
   localparam int BW = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NC-1:0]    ch_en, mode, start;
   logic [NC*CW-1:0] half_period;
   logic [NC*BW-1:0] burst_len;
   logic [NC-1:0]    clk_out, busy, done;

   prog_clk_gen #(.NUM_CH(NC), .CNT_W(CW), .BURST_W(BW)) dut (
      .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .mode(mode),
      .half_period(half_period), .burst_len(burst_len), .start(start),
      .clk_out(clk_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int    k;
      int    ch;
      logic  co;
      logic  b;
      logic  d;
      string nm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   task automatic ex(input int k, input int ch, input logic co,
                     input logic b, input logic d, input string nm);
      exp_t e;
      e.k = k; e.ch = ch; e.co = co; e.b = b; e.d = d; e.nm = nm;
      sb.push_back(e);
   endtask

   task automatic set_h(input int ch, input int v);
      half_period[ch*CW +: CW] = CW'(v);
   endtask

   task automatic set_bl(input int ch, input int v);
      burst_len[ch*BW +: BW] = BW'(v);
   endtask

   // Monitor: compare every queued expectation that falls on this cycle
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].k <= cyc) begin
            checks++;
            if (sb[i].k < cyc) begin
               failures++;
               $display("FAIL %s ch%0d: expectation for cycle %0d never checked",
                        sb[i].nm, sb[i].ch, sb[i].k);
            end else if (clk_out[sb[i].ch] !== sb[i].co ||
                         busy[sb[i].ch] !== sb[i].b ||
                         done[sb[i].ch] !== sb[i].d) begin
               failures++;
               $display("FAIL %s ch%0d cyc%0d: got clk_out=%b busy=%b done=%b want %b %b %b",
                        sb[i].nm, sb[i].ch, cyc, clk_out[sb[i].ch], busy[sb[i].ch],
                        done[sb[i].ch], sb[i].co, sb[i].b, sb[i].d);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got running want finished");
      $fatal(1, "timeout");
   end

   task automatic burst_ch1();
      int n;
      n = cyc;
      ch_en[1] = 1'b1; mode[1] = 1'b1;
      set_h(1, 2); set_bl(1, 10); start[1] = 1'b1;
      for (int j = 0; j < 22; j++)
         ex(n + 1 + j, 1, logic'((j / 2) % 2), logic'(j < 20), logic'(j == 20), "burst10");
      @(negedge clk); start[1] = 1'b0;
      repeat (4) @(negedge clk);
      start[1] = 1'b1; mode[1] = 1'b0;
      @(negedge clk); start[1] = 1'b0; mode[1] = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   initial begin
      int n;
      int hv[NC];
      rst_n = 1'b0; ch_en = '0; mode = '0; start = '0;
      half_period = '0; burst_len = '0;

      // Reset state, with ch0 already enabled during reset
      @(negedge clk); n = cyc;
      for (int c = 0; c < NC; c++) ex(n + 1, c, 1'b0, 1'b0, 1'b0, "reset");
      ch_en[0] = 1'b1; set_h(0, 5);
      @(negedge clk); @(negedge clk);
      n = cyc; rst_n = 1'b1;
      for (int j = 1; j <= 20; j++)
         ex(n + j, 0, logic'(((j - 1) / 5) % 2), 1'b1, 1'b0, "free_h5");
      repeat (20) @(negedge clk);
      n = cyc; ch_en[0] = 1'b0;
      ex(n + 1, 0, 1'b0, 1'b0, 1'b0, "free_off");
      @(negedge clk);

      // Burst of 10 with ignored start/mode during RUN
      burst_ch1();

      // Odd burst, H=0 treated as 1
      n = cyc;
      ch_en[2] = 1'b1; mode[2] = 1'b1; set_h(2, 0); set_bl(2, 3); start[2] = 1'b1;
      ex(n + 1, 2, 1'b0, 1'b1, 1'b0, "odd_entry");
      ex(n + 2, 2, 1'b1, 1'b1, 1'b0, "odd_t1");
      ex(n + 3, 2, 1'b0, 1'b1, 1'b0, "odd_t2");
      ex(n + 4, 2, 1'b1, 1'b0, 1'b1, "odd_done");
      for (int j = 5; j <= 10; j++) ex(n + j, 2, 1'b1, 1'b0, 1'b0, "odd_hold");
      @(negedge clk); start[2] = 1'b0;
      repeat (9) @(negedge clk);

      // Zero-length burst
      n = cyc;
      ch_en[3] = 1'b1; mode[3] = 1'b1; set_h(3, 4); set_bl(3, 0); start[3] = 1'b1;
      ex(n + 1, 3, 1'b0, 1'b0, 1'b1, "zero_done");
      ex(n + 2, 3, 1'b0, 1'b0, 1'b0, "zero_after");
      ex(n + 3, 3, 1'b0, 1'b0, 1'b0, "zero_after");
      ex(n + 3, 2, 1'b1, 1'b0, 1'b0, "odd_hold2");
      @(negedge clk); start[3] = 1'b0;
      repeat (2) @(negedge clk);
      n = cyc; ch_en[2] = 1'b0; ch_en[3] = 1'b0;
      ex(n + 1, 2, 1'b0, 1'b0, 1'b0, "odd_off");
      ex(n + 1, 3, 1'b0, 1'b0, 1'b0, "zero_off");
      @(negedge clk);

      // Abort mid-burst, then a full burst
      n = cyc; start[1] = 1'b1;
      for (int j = 0; j < 6; j++)
         ex(n + 1 + j, 1, logic'((j / 2) % 2), 1'b1, 1'b0, "abort_pre");
      ex(n + 7, 1, 1'b0, 1'b0, 1'b0, "abort");
      ex(n + 8, 1, 1'b0, 1'b0, 1'b0, "abort_nodone");
      @(negedge clk); start[1] = 1'b0;
      repeat (5) @(negedge clk);
      ch_en[1] = 1'b0;
      repeat (2) @(negedge clk);
      burst_ch1();
      n = cyc; ch_en[1] = 1'b0; mode[1] = 1'b0;
      ex(n + 1, 1, 1'b0, 1'b0, 1'b0, "burst_off");
      @(negedge clk);

      // Live reprogramming 3 -> 7
      n = cyc; ch_en[0] = 1'b1; mode[0] = 1'b0; set_h(0, 3);
      for (int j = 1; j <= 21; j++)
         ex(n + j, 0, logic'((j >= 4 && j < 7) || (j >= 14 && j < 21)), 1'b1, 1'b0, "reprog");
      repeat (5) @(negedge clk);
      set_h(0, 7);
      repeat (16) @(negedge clk);
      n = cyc; ch_en[0] = 1'b0;
      ex(n + 1, 0, 1'b0, 1'b0, 1'b0, "reprog_off");
      @(negedge clk);

      // Concurrent channels, then async reset between edges
      hv = '{2, 3, 4, 1};
      n = cyc; mode = '0;
      set_h(0, 2); set_h(1, 3); set_h(2, 4); set_h(3, 0);
      ch_en = '1;
      for (int j = 1; j <= 12; j++)
         for (int c = 0; c < NC; c++)
            ex(n + j, c, logic'(((j - 1) / hv[c]) % 2), 1'b1, 1'b0, "concurrent");
      repeat (12) @(negedge clk);
      for (int c = 0; c < NC; c++) ex(n + 13, c, 1'b0, 1'b0, 1'b0, "async_rst");
      @(posedge clk); #2 rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      n = cyc; rst_n = 1'b1;
      ex(n + 1, 0, 1'b0, 1'b1, 1'b0, "rst_reentry");
      ex(n + 3, 0, 1'b1, 1'b1, 1'b0, "rst_reentry_t1");
      ex(n + 3, 3, 1'b0, 1'b1, 1'b0, "rst_reentry_h0");
      repeat (4) @(negedge clk);

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/prog_clk_gen.md
PROG_CLK_GEN -- requirements
Module: prog_clk_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent clock channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of each half-period value.
REQ-003 The block SHALL have parameter BURST_W, default 8, giving the width of each burst toggle count.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port ch_en, input, NUM_CH bits: per-channel enable.
REQ-007 The block SHALL have port mode, input, NUM_CH bits: per-channel mode; 0 = free-run, 1 = burst.
REQ-008 The block SHALL have port half_period, input, NUM_CH*CNT_W bits: channel c in bits [c*CNT_W +: CNT_W], half-period in clk cycles.
REQ-009 The block SHALL have port burst_len, input, NUM_CH*BURST_W bits: channel c in bits [c*BURST_W +: BURST_W], number of output toggles per burst.
REQ-010 The block SHALL have port start, input, NUM_CH bits: per-channel burst start, one-cycle pulse.
REQ-011 The block SHALL have port clk_out, output, NUM_CH bits: generated clocks, registered.
REQ-012 The block SHALL have port busy, output, NUM_CH bits: high while the channel is in RUN.
REQ-013 The block SHALL have port done, output, NUM_CH bits: one-cycle pulse at burst completion.

Function
REQ-014 Each channel SHALL be independent and SHALL have a two-state FSM, IDLE and RUN, plus a half-period counter, a toggle counter and latched copies of mode and half-period.
REQ-015 A half_period value of 0 SHALL be treated as 1.
REQ-016 IDLE to RUN (free-run) SHALL occur at the edge where ch_en=1 and mode=0 are sampled; at that edge mode is latched and the half-period counter is cleared.
REQ-017 IDLE to RUN (burst) SHALL occur at the edge where ch_en=1, mode=1 and start=1 are sampled; at that edge clk_out is cleared to 0 and burst_len is loaded into the toggle counter.
REQ-018 In RUN, the half-period counter SHALL increment each cycle; when it reaches H-1 (H = current half-period), clk_out SHALL toggle and the counter SHALL clear.
REQ-019 The first toggle SHALL be visible H cycles after the RUN-entry edge, and the output period SHALL be 2H cycles with 50% duty.
REQ-020 half_period SHALL be sampled at RUN entry and at every toggle, so a change takes effect from the next half-period without glitches.
REQ-021 In burst mode, every toggle SHALL decrement the toggle counter; the toggle that brings it to 0 SHALL return the FSM to IDLE and assert done for exactly the following cycle.
REQ-022 A burst with burst_len=0 SHALL produce no toggles; the FSM SHALL stay in IDLE and done SHALL pulse in the cycle after start.
REQ-023 After a burst ends, clk_out SHALL hold its final level (high if burst_len is odd) until the next start or until ch_en is low.
REQ-024 start pulses received while in RUN SHALL be ignored, and changes to mode while in RUN SHALL be ignored until the next IDLE.
REQ-025 ch_en=0 sampled in any state SHALL return the channel to IDLE at that edge, force clk_out to 0, clear both counters and suppress done.
REQ-026 busy SHALL equal (state==RUN), registered and aligned with clk_out.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately, without waiting for clk, force every channel to IDLE with clk_out=0, busy=0, done=0 and all counters and latched values at 0, including mid-burst.
REQ-028 After rst_n deasserts, a free-run channel already holding ch_en=1 SHALL enter RUN at the first rising edge.

Verification
REQ-029 Free-run: ch0 H=5 with ch_en held high -> clk_out[0] period 10 clk, first rise 5 cycles after entry, busy[0]=1 throughout.
REQ-030 Burst: ch1 H=2, burst_len=10, start pulse -> exactly 10 toggles (5 high pulses) of 2 clk each, done[1] pulse 1 cycle after the last toggle, clk_out[1]=0, busy[1]=0.
REQ-031 Odd and zero bursts: burst_len=3 -> clk_out ends high and holds; burst_len=0 -> no toggle and done pulses 1 cycle after start.
REQ-032 Abort: drop ch_en mid-burst -> clk_out=0 and busy=0 at that edge, no done pulse; a new start then runs a full burst.
REQ-033 Live reprogramming and H=0: change H from 3 to 7 mid-run -> the current half-period completes at 3, the next is 7, with no short pulse; H=0 -> toggles every cycle.
REQ-034 Async reset and concurrency: rst_n low between edges during activity on all 4 channels -> outputs go to 0 before the next clk edge; channels with different H run concurrently without interaction.
